// File: rtl/puf_scan_responder.sv
// Target-side responder for a two-phase PUF scan-chain interface: serial challenge
// capture, keyed parity evaluation on Trig, and PH1-aligned serial response shift-out.
module puf_scan_responder #(
    parameter logic [127:0] KEY   = 128'h0,
    parameter int           LANES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic PH1,
    input  logic PH2,
    input  logic Ph_En,
    input  logic CA_SI,
    input  logic CB_SI,
    input  logic Trig,
    input  logic OutEn,
    output logic SO_Up,
    output logic SO_not_Up,
    output logic SO_Down,
    output logic SO_not_Down,
    output logic CAout,
    output logic CBout,
    output logic busy,
    output logic resp_valid,
    output logic overrun
);

    localparam int NBITS = 128;
    localparam int NSTEP = NBITS / LANES;
    localparam int LW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_IN,
        WAIT_TRIG,
        EVAL,
        READY,
        SHIFT_OUT
    } state_t;

    function automatic logic [NBITS-1:0] rotl(input logic [NBITS-1:0] x, input int n);
        return (x << n) | (x >> (NBITS - n));
    endfunction

    state_t state, state_n;

    // Input strobe synchronisers and edge detectors
    logic ph1_r, ph1_d, ph2_r, ph2_d, trig_r, trig_d, phen_r, phen_d, outen_r;
    logic ph1_s, ph2_s, trig_s, phen_rise;

    logic [NBITS-1:0] ch_a, ch_b;
    logic [NBITS-1:0] up_r, dn_r;
    logic [NBITS-1:0] key_rot;
    logic [7:0]       in_idx;
    logic [1:0]       spill;
    logic [6:0]       out_idx;
    logic             armed;
    logic [LW-1:0]    lane;
    logic [6:0]       lane_base;
    logic             eval_last;
    logic [LANES-1:0] up_lane, dn_lane;
    logic             enter_shift_in, enter_eval, enter_shift_out;
    logic             unused_ph1;

    assign ph1_s     = ph1_r & ~ph1_d;
    assign ph2_s     = ph2_r & ~ph2_d;
    assign trig_s    = trig_r & ~trig_d;
    assign phen_rise = phen_r & ~phen_d;

    // PH1 is registered like the other strobes but no action depends on it:
    // shift-out timing is arranged entirely around PH2.
    assign unused_ph1 = ph1_s;

    assign lane_base = 7'(int'(lane) * LANES);
    assign eval_last = (lane == LW'(NSTEP - 1));

    // NOTE: state register is purely sequential; all decisions live in the
    // combinational block below so the register stays a plain flop bank.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:      if (phen_rise) state_n = SHIFT_IN;
            SHIFT_IN:  if (!phen_r)   state_n = WAIT_TRIG;
            WAIT_TRIG: begin
                if (phen_rise)   state_n = SHIFT_IN;
                else if (trig_s) state_n = EVAL;
            end
            EVAL:      if (eval_last) state_n = READY;
            READY: begin
                if (phen_rise)    state_n = SHIFT_IN;
                else if (outen_r) state_n = SHIFT_OUT;
            end
            SHIFT_OUT: if (!outen_r) state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    assign enter_shift_in  = (state_n == SHIFT_IN)  && (state != SHIFT_IN);
    assign enter_eval      = (state_n == EVAL)      && (state == WAIT_TRIG);
    assign enter_shift_out = (state_n == SHIFT_OUT) && (state == READY);

    // key_rot holds rotl(KEY, lane*LANES), so each lane needs only constant rotations.
    always_comb begin
        up_lane = '0;
        dn_lane = '0;
        for (int j = 0; j < LANES; j++) begin
            up_lane[j] = ^(ch_a & rotl(key_rot, j)) ^ ch_b[lane_base + 7'(j)];
            dn_lane[j] = ^(ch_b & rotl(key_rot, j)) ^ ch_a[lane_base + 7'(j)];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            ph1_r      <= 1'b0;
            ph1_d      <= 1'b0;
            ph2_r      <= 1'b0;
            ph2_d      <= 1'b0;
            trig_r     <= 1'b0;
            trig_d     <= 1'b0;
            phen_r     <= 1'b0;
            phen_d     <= 1'b0;
            outen_r    <= 1'b0;
            // NOTE: challenge and response arrays are reset explicitly because the
            // serial outputs expose them directly and must read 0 / inverted 1.
            ch_a       <= '0;
            ch_b       <= '0;
            up_r       <= '0;
            dn_r       <= '0;
            key_rot    <= '0;
            in_idx     <= '0;
            spill      <= '0;
            out_idx    <= '0;
            armed      <= 1'b0;
            lane       <= '0;
            CAout      <= 1'b0;
            CBout      <= 1'b0;
            resp_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            ph1_r   <= PH1;
            ph1_d   <= ph1_r;
            ph2_r   <= PH2;
            ph2_d   <= ph2_r;
            trig_r  <= Trig;
            trig_d  <= trig_r;
            phen_r  <= Ph_En;
            phen_d  <= phen_r;
            outen_r <= OutEn;

            if (enter_shift_in) begin
                in_idx     <= '0;
                spill      <= '0;
                resp_valid <= 1'b0;
            end else if (state == SHIFT_IN && phen_r && ph2_s) begin
                if (!in_idx[7]) begin
                    ch_a[in_idx[6:0]] <= CA_SI;
                    ch_b[in_idx[6:0]] <= CB_SI;
                    CAout             <= CA_SI;
                    CBout             <= CB_SI;
                    in_idx            <= in_idx + 8'd1;
                end else begin
                    // The first spilled strobe is the initiator's normal trailer.
                    if (spill != 2'd2) spill <= spill + 2'd1;
                    if (spill != 2'd0) overrun <= 1'b1;
                end
            end

            if (enter_eval) begin
                lane    <= '0;
                key_rot <= KEY;
            end else if (state == EVAL) begin
                up_r[lane_base +: LANES] <= up_lane;
                dn_r[lane_base +: LANES] <= dn_lane;
                lane                     <= lane + LW'(1);
                key_rot                  <= rotl(key_rot, LANES);
                if (eval_last) resp_valid <= 1'b1;
            end

            if (enter_shift_out) begin
                out_idx <= '0;
                armed   <= 1'b0;
            end else if (state == SHIFT_OUT && outen_r && ph2_s) begin
                // Arming on the first PH2 holds bit 0 through the first PH1 sample.
                if (!armed)                 armed   <= 1'b1;
                else if (out_idx != 7'd127) out_idx <= out_idx + 7'd1;
            end
        end
    end

    assign busy        = (state != IDLE);
    assign SO_Up       = up_r[out_idx];
    assign SO_not_Up   = ~up_r[out_idx];
    assign SO_Down     = dn_r[out_idx];
    assign SO_not_Down = ~dn_r[out_idx];

endmodule

// File: tb/tb_puf_scan_responder.sv
// Scoreboard bench for puf_scan_responder: two instances (KEY=0, KEY=all-ones) share one
// initiator; a passive monitor assembles shifted-out streams and checks them against the queue.
module tb_puf_scan_responder;

    logic clk = 1'b0;
    logic rst, PH1, PH2, Ph_En, CA_SI, CB_SI, Trig, OutEn;

    logic so_up0, so_nup0, so_dn0, so_ndn0, caout0, cbout0, busy0, valid0, ovr0;
    logic so_up1, so_nup1, so_dn1, so_ndn1, caout1, cbout1, busy1, valid1, ovr1;

    typedef struct {
        logic [127:0] up0;
        logic [127:0] dn0;
        logic [127:0] up1;
        logic [127:0] dn1;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    puf_scan_responder #(.KEY(128'h0), .LANES(32)) u_dut0 (
        .clk(clk), .rst(rst), .PH1(PH1), .PH2(PH2), .Ph_En(Ph_En),
        .CA_SI(CA_SI), .CB_SI(CB_SI), .Trig(Trig), .OutEn(OutEn),
        .SO_Up(so_up0), .SO_not_Up(so_nup0), .SO_Down(so_dn0), .SO_not_Down(so_ndn0),
        .CAout(caout0), .CBout(cbout0), .busy(busy0), .resp_valid(valid0), .overrun(ovr0)
    );

    puf_scan_responder #(.KEY({128{1'b1}}), .LANES(32)) u_dut1 (
        .clk(clk), .rst(rst), .PH1(PH1), .PH2(PH2), .Ph_En(Ph_En),
        .CA_SI(CA_SI), .CB_SI(CB_SI), .Trig(Trig), .OutEn(OutEn),
        .SO_Up(so_up1), .SO_not_Up(so_nup1), .SO_Down(so_dn1), .SO_not_Down(so_ndn1),
        .CAout(caout1), .CBout(cbout1), .busy(busy1), .resp_valid(valid1), .overrun(ovr1)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // KEY=0: every key parity term vanishes, so Up=chB and Down=chA.
    // KEY=all-ones: every rotation is all-ones, so the term is parity of the other challenge.
    function automatic exp_t expect_of(input logic [127:0] a, input logic [127:0] b);
        exp_t e;
        e.up0 = b;
        e.dn0 = a;
        e.up1 = {128{^a}} ^ b;
        e.dn1 = {128{^b}} ^ a;
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ph1_pulse();
        PH1 = 1'b1; tick(2); PH1 = 1'b0; tick(2);
    endtask

    task automatic ph2_pulse();
        PH2 = 1'b1; tick(2); PH2 = 1'b0; tick(2);
    endtask

    task automatic strobe_bit(input logic a, input logic b);
        CA_SI = a;
        CB_SI = b;
        ph1_pulse();
        ph2_pulse();
    endtask

    task automatic open_window();
        Ph_En = 1'b1; tick(4);
    endtask

    task automatic close_window();
        Ph_En = 1'b0; tick(4);
    endtask

    // Strobes with index >= 128 are spill strobes carrying zeros.
    task automatic load(input logic [127:0] a, input logic [127:0] b, input int first, input int last);
        for (int i = first; i < last; i++) begin
            if (i < 128) strobe_bit(a[i], b[i]);
            else         strobe_bit(1'b0, 1'b0);
        end
    endtask

    task automatic evaluate();
        int lat;
        Trig = 1'b1;
        @(posedge clk);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!valid0 && lat < 20);
        check("trig_to_valid_clks", 128'(lat), 128'd5);
        check("valid_key1", {127'd0, valid1}, 128'd1);
        @(negedge clk);
        Trig = 1'b0;
        tick(2);
    endtask

    task automatic shift_out();
        OutEn = 1'b1;
        tick(4);
        for (int k = 0; k < 128; k++) begin
            ph2_pulse();
            ph1_pulse();
        end
        OutEn = 1'b0;
        tick(4);
    endtask

    task automatic run_full(input logic [127:0] a, input logic [127:0] b);
        open_window();
        load(a, b, 0, 129);
        close_window();
        sb_q.push_back(expect_of(a, b));
        evaluate();
        shift_out();
    endtask

    // Passive monitor: samples all serial outputs at each PH1 rise while OutEn is high.
    initial begin
        logic [127:0] g_up0, g_nup0, g_dn0, g_ndn0, g_up1, g_nup1, g_dn1, g_ndn1;
        exp_t e;
        int   n;
        forever begin
            @(posedge OutEn);
            n = 0;
            while (OutEn) begin
                @(posedge PH1 or negedge OutEn);
                if (OutEn && n < 128) begin
                    g_up0[n] = so_up0; g_nup0[n] = so_nup0; g_dn0[n] = so_dn0; g_ndn0[n] = so_ndn0;
                    g_up1[n] = so_up1; g_nup1[n] = so_nup1; g_dn1[n] = so_dn1; g_ndn1[n] = so_ndn1;
                    n++;
                end
            end
            check("shift_bit_count", 128'(n), 128'd128);
            check("scoreboard_nonempty", {127'd0, sb_q.size() != 0}, 128'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("up_key0",      g_up0,  e.up0);
                check("not_up_key0",  g_nup0, ~e.up0);
                check("down_key0",    g_dn0,  e.dn0);
                check("not_down_key0", g_ndn0, ~e.dn0);
                check("up_key1",      g_up1,  e.up1);
                check("not_up_key1",  g_nup1, ~e.up1);
                check("down_key1",    g_dn1,  e.dn1);
                check("not_down_key1", g_ndn1, ~e.dn1);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] a, b;
        rst = 1'b1; PH1 = 1'b0; PH2 = 1'b0; Ph_En = 1'b0;
        CA_SI = 1'b0; CB_SI = 1'b0; Trig = 1'b0; OutEn = 1'b0;
        tick(4);
        check("rst_busy",        {127'd0, busy0},   128'd0);
        check("rst_resp_valid",  {127'd0, valid0},  128'd0);
        check("rst_overrun",     {127'd0, ovr0},    128'd0);
        check("rst_so_up",       {127'd0, so_up0},  128'd0);
        check("rst_so_not_up",   {127'd0, so_nup0}, 128'd1);
        check("rst_so_down",     {127'd0, so_dn0},  128'd0);
        check("rst_so_not_down", {127'd0, so_ndn0}, 128'd1);
        check("rst_caout",       {127'd0, caout0},  128'd0);
        rst = 1'b0;
        tick(2);

        // Alternating nibble pattern with complementary B, one normal trailer strobe.
        a = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        b = ~a;
        run_full(a, b);
        check("t1_overrun", {127'd0, ovr0},   128'd0);
        check("t1_caout",   {127'd0, caout0}, {127'd0, a[127]});
        check("t1_cbout",   {127'd0, cbout0}, {127'd0, b[127]});

        // Back-to-back: resp_valid persists in IDLE, then drops on the new Ph_En rise.
        check("t2_valid_held", {127'd0, valid0}, 128'd1);
        a = 128'h1;
        b = 128'h0;
        open_window();
        check("t2_valid_drop", {127'd0, valid0}, 128'd0);
        load(a, b, 0, 129);
        close_window();
        sb_q.push_back(expect_of(a, b));
        evaluate();
        shift_out();

        // Trig during the shift-in window is ignored.
        a = 128'hDEAD_BEEF_0000_FFFF_1234_5678_9ABC_DEF0;
        b = 128'h0F0F_0F0F_A5A5_5A5A_C3C3_3C3C_8001_7FFE;
        open_window();
        load(a, b, 0, 64);
        Trig = 1'b1; tick(2); Trig = 1'b0; tick(8);
        check("t3_valid_low", {127'd0, valid0}, 128'd0);
        check("t3_busy",      {127'd0, busy0},  128'd1);
        load(a, b, 64, 129);
        close_window();
        sb_q.push_back(expect_of(a, b));
        evaluate();
        shift_out();

        // Overrun: 129 strobes is tolerated, the 130th sets the sticky flag.
        a = 128'h8000_0000_0000_0001_FFFF_0000_1111_2222;
        b = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
        open_window();
        load(a, b, 0, 129);
        check("t4_no_overrun_129", {127'd0, ovr0}, 128'd0);
        strobe_bit(1'b1, 1'b1);
        check("t4_overrun_130", {127'd0, ovr0}, 128'd1);
        close_window();
        sb_q.push_back(expect_of(a, b));
        evaluate();
        shift_out();

        // Reset while EVAL is working on lane 2.
        a = 128'hCAFE_F00D_1357_9BDF_2468_ACE0_FFFF_FFFF;
        b = 128'h0000_0001_0000_0002_0000_0004_0000_0008;
        open_window();
        load(a, b, 0, 129);
        close_window();
        Trig = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t5_eval_busy",     {127'd0, busy0},  128'd1);
        check("t5_eval_not_done", {127'd0, valid0}, 128'd0);
        rst  = 1'b1;
        Trig = 1'b0;
        @(posedge clk);
        #1;
        check("t5_rst_busy",      {127'd0, busy0},   128'd0);
        check("t5_rst_valid",     {127'd0, valid0},  128'd0);
        check("t5_rst_so_up",     {127'd0, so_up0},  128'd0);
        check("t5_rst_so_not_up", {127'd0, so_nup0}, 128'd1);
        check("t5_rst_overrun",   {127'd0, ovr0},    128'd0);
        @(negedge clk);
        rst = 1'b0;
        tick(4);

        // Full sequence after the aborted evaluation.
        a = 128'h5555_AAAA_0F0F_F0F0_3333_CCCC_0123_ABCD;
        b = 128'h9876_5432_10FE_DCBA_0000_FFFF_8888_7777;
        run_full(a, b);

        tick(10);
        check("scoreboard_drained", 128'(sb_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
